mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction-fetch port and its load/store port, so the core can run on a unified memory.
- Sits between the datapath/control pair and the memory model.
- Serialises requests and generates the `stall` that freezes the PC register while a fetch or data access is outstanding.
- Adds starvation protection and a per-transaction timeout with a sticky error flag.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/arb_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified-memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  localparam int unsigned TIMER_W  = 16;
  localparam logic [3:0]  FETCH_BE = 4'hF;

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - loadable up-counter with clear and terminal-count flag
module arb_timer #(
  parameter int W  = 16,
  parameter int TC = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(TC));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store onto one memory port,
// with fetch starvation guard and per-transaction timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          stall,
  output logic          err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  state_e          state_q, state_d;
  src_e            src_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [SW-1:0]   dstreak_q, dstreak_d;
  logic [31:0]     if_rdata_q, d_rdata_q;
  logic            if_done_q, d_done_q, err_q;

  logic            d_wins, load_fields, finish, abort, timer_tc, timer_en;
  logic [31:0]     rdata_next;

  // Data normally wins a collision; a fetch that has watched MAX_DSTREAK data wins goes first.
  assign d_wins = d_req & ~(if_req & (dstreak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    dstreak_d   = dstreak_q;
    load_fields = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d     = REQ;
          load_fields = 1'b1;
          dstreak_d   = (d_wins & if_req) ? dstreak_q + SW'(1) : '0;
        end
      end
      REQ: begin
        if (timer_tc) begin
          state_d = DONE;
          abort   = 1'b1;
        end else if (mem_ack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = DONE;
          finish  = 1'b1;
        end else if (timer_tc) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rdata_next = finish ? mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_IF;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      dstreak_q  <= '0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      if (load_fields) begin
        src_q   <= d_wins ? SRC_D : SRC_IF;
        we_q    <= d_wins & d_we;
        be_q    <= d_wins ? d_be : FETCH_BE;
        addr_q  <= d_wins ? d_addr : if_addr;
        wdata_q <= d_wins ? d_wdata : 32'h0;
      end
      if_done_q <= (finish | abort) & (src_q == SRC_IF);
      d_done_q  <= (finish | abort) & (src_q == SRC_D);
      if ((finish | abort) && src_q == SRC_IF) begin
        if_rdata_q <= rdata_next;
      end
      if ((finish | abort) && src_q == SRC_D) begin
        d_rdata_q <= rdata_next;
      end
      err_q <= err_q | abort;
    end
  end

  assign timer_en = (state_q == REQ) | (state_q == RESP);

  arb_timer #(
    .W  (TIMER_W),
    .TC (TIMEOUT - 1)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (load_fields),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (timer_en),
    .tc     (timer_tc)
  );

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  // Gated by reset so stall is low immediately while held in reset.
  assign stall     = reset & ((if_req & ~if_done_q) | (d_req & ~d_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic        err;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(
    .AW          (32),
    .MAX_DSTREAK (4),
    .TIMEOUT     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in an IDLE cycle with a request present; zero-wait memory.
  task automatic serve(input logic [31:0] rd, output logic mreq, output logic [31:0] addr_seen,
                       output logic ifd, output logic dd);
    tick();
    mreq      = mem_req;
    addr_seen = mem_addr;
    mem_ack   = 1'b1;
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    ifd        = if_done;
    dd         = d_done;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic        mreq_s, ifd_s, dd_s;
  logic [31:0] addr_s;
  int          n;
  logic [31:0] exp_addr [6];
  logic        exp_d    [6];

  initial begin
    // Reset state
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_d_done", 32'(d_done), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single fetch, zero-wait memory
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    chk("f_stall_t0", 32'(stall), 32'h1);
    tick();
    chk("f_mem_req_t1", 32'(mem_req), 32'h1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", 32'(mem_be), 32'hF);
    chk("f_mem_we", 32'(mem_we), 32'h0);
    chk("f_stall_t1", 32'(stall), 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("f_mem_req_t2", 32'(mem_req), 32'h0);
    chk("f_stall_t2", 32'(stall), 32'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00500093;
    tick();
    mem_rvalid = 1'b0;
    chk("f_if_done_t3", 32'(if_done), 32'h1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_d_done_t3", 32'(d_done), 32'h0);
    chk("f_stall_t3", 32'(stall), 32'h0);
    if_req = 1'b0;
    tick();
    chk("f_if_done_t4", 32'(if_done), 32'h0);
    chk("f_if_rdata_hold", if_rdata, 32'h00500093);

    // Store with ack delayed by two cycles
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    tick();
    chk("s_mem_req_1", 32'(mem_req), 32'h1);
    chk("s_mem_we", 32'(mem_we), 32'h1);
    chk("s_mem_be", 32'(mem_be), 32'h3);
    chk("s_mem_addr_1", mem_addr, 32'h2000);
    chk("s_mem_wdata_1", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("s_mem_req_2", 32'(mem_req), 32'h1);
    chk("s_mem_addr_2", mem_addr, 32'h2000);
    tick();
    chk("s_mem_req_3", 32'(mem_req), 32'h1);
    chk("s_mem_wdata_3", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("s_mem_req_resp", 32'(mem_req), 32'h0);
    chk("s_d_done_early", 32'(d_done), 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("s_d_done", 32'(d_done), 32'h1);
    chk("s_if_done", 32'(if_done), 32'h0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk("s_d_done_clr", 32'(d_done), 32'h0);

    // Both ports held: data wins four times, then fetch, then data again
    exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    exp_d    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_addr  = 32'h400;
    d_be    = 4'hF;
    for (int i = 0; i < 6; i++) begin
      serve(32'hA0000000 + 32'(i), mreq_s, addr_s, ifd_s, dd_s);
      chk($sformatf("arb_addr_%0d", i), addr_s, exp_addr[i]);
      chk($sformatf("arb_d_done_%0d", i), 32'(dd_s), 32'(exp_d[i]));
      chk($sformatf("arb_if_done_%0d", i), 32'(ifd_s), 32'(!exp_d[i]));
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("arb_if_rdata", if_rdata, 32'hA0000004);
    chk("arb_d_rdata", d_rdata, 32'hA0000005);
    tick();

    // Timeout: memory never acks
    d_req  = 1'b1;
    d_addr = 32'h500;
    tick();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd8);
    chk("to_d_done", 32'(d_done), 32'h1);
    chk("to_d_rdata", d_rdata, 32'h0);
    chk("to_err", 32'(err), 32'h1);
    chk("to_if_done", 32'(if_done), 32'h0);
    d_req = 1'b0;
    tick();
    chk("to_d_done_clr", 32'(d_done), 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    chk("late_d_done", 32'(d_done), 32'h0);
    chk("late_if_done", 32'(if_done), 32'h0);
    tick();
    chk("late_d_done_2", 32'(d_done), 32'h0);
    chk("late_mem_req", 32'(mem_req), 32'h0);
    chk("to_err_sticky", 32'(err), 32'h1);

    // Fetch after a timeout completes normally
    if_req  = 1'b1;
    if_addr = 32'h600;
    serve(32'h12345678, mreq_s, addr_s, ifd_s, dd_s);
    if_req = 1'b0;
    chk("post_to_mem_req", 32'(mreq_s), 32'h1);
    chk("post_to_addr", addr_s, 32'h600);
    chk("post_to_if_done", 32'(ifd_s), 32'h1);
    chk("post_to_d_done", 32'(dd_s), 32'h0);
    chk("post_to_if_rdata", if_rdata, 32'h12345678);
    chk("post_to_err", 32'(err), 32'h1);

    // Asynchronous reset in the middle of RESP
    if_req  = 1'b1;
    if_addr = 32'h700;
    tick();
    chk("ar_mem_req_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_mem_req", 32'(mem_req), 32'h0);
    chk("ar_stall", 32'(stall), 32'h0);
    chk("ar_err", 32'(err), 32'h0);
    chk("ar_if_done", 32'(if_done), 32'h0);
    chk("ar_d_done", 32'(d_done), 32'h0);
    chk("ar_if_rdata", if_rdata, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBADBAD00;
    tick();
    mem_rvalid = 1'b0;
    chk("ar_stray_if_done", 32'(if_done), 32'h0);
    chk("ar_stray_d_done", 32'(d_done), 32'h0);
    tick();
    chk("ar_stray_if_done_2", 32'(if_done), 32'h0);
    if_req  = 1'b1;
    if_addr = 32'h800;
    serve(32'h00000055, mreq_s, addr_s, ifd_s, dd_s);
    if_req = 1'b0;
    chk("ar_next_mem_req", 32'(mreq_s), 32'h1);
    chk("ar_next_addr", addr_s, 32'h800);
    chk("ar_next_if_done", 32'(ifd_s), 32'h1);
    chk("ar_next_if_rdata", if_rdata, 32'h00000055);
    chk("ar_next_err", 32'(err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
